player_ctl: RTL and testbench



---
 rtl/player_pkg.sv | 25 ++
 rtl/player_if.sv | 25 ++
 rtl/player_surface_sel.sv | 25 ++
 rtl/player_ctl.sv | 207 ++++++++++++++++++++
 tb/tb_player_ctl.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/player_pkg.sv
// Shared types and default geometry/physics constants for the per-player movement controller.
package player_pkg;

   typedef enum logic [1:0] {
      GROUNDED = 2'b00,
      RISE     = 2'b01,
      FALL     = 2'b10
   } state_t;

   localparam int POS_W = 12;
   localparam int Y_W   = 13;

   localparam int DEF_SCREEN_W = 1024;
   localparam int DEF_FLOOR_Y  = 600;
   localparam int DEF_PLAYER_W = 32;
   localparam int DEF_PLAYER_H = 48;
   localparam int DEF_X_INIT   = 100;
   localparam int DEF_X_MAX    = DEF_SCREEN_W - DEF_PLAYER_W;
   localparam int DEF_RECT_W   = 128;
   localparam int DEF_STEP     = 4;
   localparam int DEF_JUMP_V0  = 12;
   localparam int DEF_GRAVITY  = 1;
   localparam int DEF_VMAX     = 8;

endpackage

// File: rtl/player_if.sv
// Key/platform inputs and position outputs of one player controller.
interface player_if;
   import player_pkg::*;

   logic             v_tick;
   logic             left;
   logic             right;
   logic             jump;
   logic [POS_W-1:0] xpos_rect;
   logic [POS_W-1:0] ypos_rect;
   logic [POS_W-1:0] xpos_player;
   logic [POS_W-1:0] ypos_player;
   logic             airborne;

   modport master (
      output v_tick, left, right, jump, xpos_rect, ypos_rect,
      input  xpos_player, ypos_player, airborne
   );

   modport slave (
      input  v_tick, left, right, jump, xpos_rect, ypos_rect,
      output xpos_player, ypos_player, airborne
   );

endinterface

// File: rtl/player_surface_sel.sv
// Picks the surface under the player's new x: platform top when horizontally overlapping, else floor.
module player_surface_sel
   import player_pkg::*;
#(
   parameter int FLOOR_Y  = DEF_FLOOR_Y,
   parameter int PLAYER_W = DEF_PLAYER_W,
   parameter int RECT_W   = DEF_RECT_W
) (
   input  logic [POS_W-1:0] x_new,
   input  logic [POS_W-1:0] xpos_rect,
   input  logic [POS_W-1:0] ypos_rect,
   output logic             overlap,
   output logic [POS_W-1:0] surface
);

   logic [POS_W:0] player_end;
   logic [POS_W:0] rect_end;

   assign player_end = {1'b0, x_new} + (POS_W+1)'(PLAYER_W);
   assign rect_end   = {1'b0, xpos_rect} + (POS_W+1)'(RECT_W);

   assign overlap = (player_end > {1'b0, xpos_rect}) && ({1'b0, x_new} < rect_end);
   assign surface = overlap ? ypos_rect : POS_W'(FLOOR_Y);

endmodule

// File: rtl/player_ctl.sv
// Per-player movement controller: keys -> x/y once per frame, with gravity, jumps and platform carry.
// Optional build macro PLAYER_DOUBLE_JUMP_EN allows one extra jump while airborne.
module player_ctl
   import player_pkg::*;
#(
   parameter int X_INIT   = DEF_X_INIT,
   parameter int FLOOR_Y  = DEF_FLOOR_Y,
   parameter int PLAYER_W = DEF_PLAYER_W,
   parameter int PLAYER_H = DEF_PLAYER_H,
   parameter int X_MAX    = DEF_X_MAX,
   parameter int RECT_W   = DEF_RECT_W,
   parameter int STEP     = DEF_STEP,
   parameter int JUMP_V0  = DEF_JUMP_V0,
   parameter int GRAVITY  = DEF_GRAVITY,
   parameter int VMAX     = DEF_VMAX
) (
   input logic   clk,
   input logic   rst,
   player_if.slave pif
);

   localparam logic signed [Y_W-1:0] STEP_S  = Y_W'(STEP);
   localparam logic signed [Y_W-1:0] X_MAX_S = Y_W'(X_MAX);
   localparam logic signed [Y_W-1:0] H_S     = Y_W'(PLAYER_H);
   localparam logic signed [Y_W-1:0] FLOOR_S = Y_W'(FLOOR_Y);
   localparam logic signed [Y_W-1:0] Y_MAX_S = Y_W'(FLOOR_Y - PLAYER_H);

   function automatic logic [POS_W-1:0] clamp_x(input logic signed [Y_W-1:0] v);
      if (v < 0)
         return '0;
      else if (v > X_MAX_S)
         return POS_W'(X_MAX);
      else
         return v[POS_W-1:0];
   endfunction

   function automatic logic [POS_W-1:0] clamp_y(input logic signed [Y_W-1:0] v);
      if (v < 0)
         return '0;
      else if (v > Y_MAX_S)
         return POS_W'(FLOOR_Y - PLAYER_H);
      else
         return v[POS_W-1:0];
   endfunction

   function automatic logic [7:0] fall_vel(input logic [7:0] v);
      logic [8:0] s;
      s = {1'b0, v} + 9'(GRAVITY);
      return (s > 9'(VMAX)) ? 8'(VMAX) : s[7:0];
   endfunction

   state_t           state, state_nxt;
   logic [7:0]       vel, vel_nxt;
   logic [POS_W-1:0] x, x_nxt;
   logic [POS_W-1:0] y, y_nxt;
   logic [POS_W-1:0] rect_y_d;
   logic             v_tick_d;
   logic             jump_d;
`ifdef PLAYER_DOUBLE_JUMP_EN
   logic             dj_used, dj_nxt;
`endif

   logic frame;
   logic press;
   assign frame = pif.v_tick & ~v_tick_d;
   assign press = pif.jump & ~jump_d;

   logic signed [Y_W-1:0] x_s, x_sum;
   always_comb begin
      x_s   = signed'({1'b0, x});
      x_sum = x_s;
      if (pif.left && !pif.right)
         x_sum = x_s - STEP_S;
      else if (pif.right && !pif.left)
         x_sum = x_s + STEP_S;
      x_nxt = clamp_x(x_sum);
   end

   logic             overlap;
   logic [POS_W-1:0] surface;

   player_surface_sel #(
      .FLOOR_Y  (FLOOR_Y),
      .PLAYER_W (PLAYER_W),
      .RECT_W   (RECT_W)
   ) u_surface_sel (
      .x_new     (x_nxt),
      .xpos_rect (pif.xpos_rect),
      .ypos_rect (pif.ypos_rect),
      .overlap   (overlap),
      .surface   (surface)
   );

   logic signed [Y_W-1:0] y_s, vel_s, feet, surf_s, rect_s, rise_y, fall_y, new_feet;
   logic [7:0]            fv;
   logic                  carried;

   always_comb begin
      y_s      = signed'({1'b0, y});
      vel_s    = signed'({5'b0, vel});
      feet     = y_s + H_S;
      surf_s   = signed'({1'b0, surface});
      rect_s   = signed'({1'b0, pif.ypos_rect});
      rise_y   = y_s - vel_s;
      fv       = fall_vel(vel);
      fall_y   = y_s + signed'({5'b0, fv});
      new_feet = fall_y + H_S;
      // standing on the platform last frame and still over it: follow its new height
      carried  = overlap && (feet == signed'({1'b0, rect_y_d}));
   end

   always_comb begin
      state_nxt = state;
      vel_nxt   = vel;
      y_nxt     = y;
`ifdef PLAYER_DOUBLE_JUMP_EN
      dj_nxt    = dj_used;
`endif
      unique case (state)
         GROUNDED: begin
            if (press) begin
               state_nxt = RISE;
               vel_nxt   = 8'(JUMP_V0);
            end else if (carried) begin
               y_nxt = clamp_y(rect_s - H_S);
            end else if (feet < FLOOR_S) begin
               state_nxt = FALL;
               vel_nxt   = '0;
            end
         end
         RISE: begin
            if (rise_y < 0) begin
               y_nxt     = '0;
               vel_nxt   = '0;
               state_nxt = FALL;
            end else begin
               y_nxt   = rise_y[POS_W-1:0];
               vel_nxt = (vel > 8'(GRAVITY)) ? vel - 8'(GRAVITY) : '0;
               if (vel <= 8'(GRAVITY))
                  state_nxt = FALL;
            end
         end
         FALL: begin
            vel_nxt = fv;
            // floor check backs up the platform check when falling beneath the platform
            if ((feet <= surf_s && new_feet >= surf_s) || new_feet >= FLOOR_S) begin
               y_nxt     = (feet <= surf_s && new_feet >= surf_s) ? clamp_y(surf_s - H_S)
                                                                  : clamp_y(FLOOR_S - H_S);
               vel_nxt   = '0;
               state_nxt = GROUNDED;
`ifdef PLAYER_DOUBLE_JUMP_EN
               dj_nxt    = 1'b0;
`endif
            end else begin
               y_nxt = fall_y[POS_W-1:0];
            end
         end
         default: begin
            state_nxt = GROUNDED;
            vel_nxt   = '0;
         end
      endcase
`ifdef PLAYER_DOUBLE_JUMP_EN
      if (state != GROUNDED && press && !dj_used) begin
         state_nxt = RISE;
         vel_nxt   = 8'(JUMP_V0);
         y_nxt     = y;
         dj_nxt    = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= GROUNDED;
         vel      <= '0;
         x        <= POS_W'(X_INIT);
         y        <= POS_W'(FLOOR_Y - PLAYER_H);
         rect_y_d <= '0;
         v_tick_d <= 1'b0;
         jump_d   <= 1'b0;
`ifdef PLAYER_DOUBLE_JUMP_EN
         dj_used  <= 1'b0;
`endif
      end else begin
         v_tick_d <= pif.v_tick;
         if (frame) begin
            state    <= state_nxt;
            vel      <= vel_nxt;
            x        <= x_nxt;
            y        <= y_nxt;
            rect_y_d <= pif.ypos_rect;
            jump_d   <= pif.jump;
`ifdef PLAYER_DOUBLE_JUMP_EN
            dj_used  <= dj_nxt;
`endif
         end
      end
   end

   always_comb begin
      pif.airborne    = (state != GROUNDED);
      pif.xpos_player = x;
      pif.ypos_player = y;
   end

endmodule

// File: tb/tb_player_ctl.sv
// Directed bench for player_ctl: walking, clamping, jump arc, platform landing/carry/walk-off, reset.
// Honours PLAYER_DOUBLE_JUMP_EN for the airborne-press scenario.
module tb_player_ctl;
   import player_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   vec_cnt = 0;
   int   err_cnt = 0;

   player_if pif ();

   player_ctl dut (
      .clk (clk),
      .rst (rst),
      .pif (pif.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic frame();
      pif.v_tick = 1'b1;
      @(posedge clk); #1;
      pif.v_tick = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic keys(input logic l, input logic r, input logic j);
      pif.left  = l;
      pif.right = r;
      pif.jump  = j;
   endtask

   int rise_y [12] = '{540, 529, 519, 510, 502, 495, 489, 484, 480, 477, 475, 474};
   int fall_y [14] = '{475, 477, 480, 484, 489, 495, 502, 510, 518, 526, 534, 542, 550, 552};
   int plat_y [6]  = '{475, 477, 480, 484, 489, 492};

   initial begin
      int n;
      keys(0, 0, 0);
      pif.v_tick    = 1'b0;
      pif.xpos_rect = 12'd476;
      pif.ypos_rect = 12'd540;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_x", pif.xpos_player, 100);
      chk("reset_y", pif.ypos_player, 552);
      chk("reset_air", pif.airborne, 0);
      rst = 1'b1;

      // idle frames
      for (int i = 0; i < 5; i++) begin
         frame();
         chk("idle_x", pif.xpos_player, 100);
         chk("idle_y", pif.ypos_player, 552);
         chk("idle_air", pif.airborne, 0);
      end

      // single jump from the floor, jump held throughout
      keys(0, 0, 1);
      frame();
      chk("jump_start_y", pif.ypos_player, 552);
      chk("jump_start_air", pif.airborne, 1);
      for (int i = 0; i < 12; i++) begin
         frame();
         chk("rise_y", pif.ypos_player, rise_y[i]);
      end
      for (int i = 0; i < 14; i++) begin
         frame();
         chk("fall_y", pif.ypos_player, fall_y[i]);
      end
      chk("land_air", pif.airborne, 0);
      for (int i = 0; i < 3; i++) begin
         frame();
         chk("hold_jump_y", pif.ypos_player, 552);
         chk("hold_jump_air", pif.airborne, 0);
      end
      keys(0, 0, 0);
      frame();

      // reset mid-rise while moving right
      keys(0, 1, 1);
      frame();
      frame();
      frame();
      chk("midrise_x", pif.xpos_player, 112);
      chk("midrise_y", pif.ypos_player, 529);
      rst = 1'b0;
      keys(0, 0, 0);
      @(posedge clk); #1;
      chk("rst_mid_x", pif.xpos_player, 100);
      chk("rst_mid_y", pif.ypos_player, 552);
      chk("rst_mid_air", pif.airborne, 0);
      rst = 1'b1;

      // walk to 980, then clamp at 992
      keys(0, 1, 0);
      for (int i = 0; i < 220; i++) frame();
      chk("walk_x", pif.xpos_player, 980);
      for (int i = 0; i < 10; i++) begin
         frame();
         chk("right_clamp_x", pif.xpos_player, (980 + 4 * (i + 1) > 992) ? 992 : 980 + 4 * (i + 1));
      end
      keys(1, 1, 0);
      frame();
      frame();
      chk("both_keys_x", pif.xpos_player, 992);

      // walk back to x=500 under the platform
      keys(1, 0, 0);
      for (int i = 0; i < 123; i++) frame();
      chk("walk_back_x", pif.xpos_player, 500);
      chk("under_plat_y", pif.ypos_player, 552);

      // jump onto the platform at (476,540)
      keys(0, 0, 1);
      frame();
      for (int i = 0; i < 12; i++) frame();
      chk("plat_peak_y", pif.ypos_player, 474);
      for (int i = 0; i < 6; i++) begin
         frame();
         chk("plat_fall_y", pif.ypos_player, plat_y[i]);
      end
      chk("plat_land_air", pif.airborne, 0);
      keys(0, 0, 0);
      frame();
      chk("plat_rest_y", pif.ypos_player, 492);

      // platform rises 1 px/frame to 412, player carried
      for (int r = 539; r >= 412; r--) begin
         pif.ypos_rect = 12'(r);
         frame();
         chk("carry_y", pif.ypos_player, r - 48);
      end
      chk("carry_air", pif.airborne, 0);

      // walk off the left edge
      keys(1, 0, 0);
      for (int i = 0; i < 13; i++) frame();
      chk("edge_x", pif.xpos_player, 448);
      chk("edge_y", pif.ypos_player, 364);
      chk("edge_air", pif.airborne, 0);
      frame();
      chk("walkoff_x", pif.xpos_player, 444);
      chk("walkoff_y", pif.ypos_player, 364);
      chk("walkoff_air", pif.airborne, 1);
      keys(0, 0, 0);
      n = 0;
      while (pif.airborne && n < 40) begin
         frame();
         n++;
      end
      chk("walkoff_frames", n, 27);
      chk("walkoff_land_y", pif.ypos_player, 552);
      chk("walkoff_land_air", pif.airborne, 0);

      // press while airborne
      keys(0, 0, 1);
      frame();
      for (int i = 0; i < 12; i++) frame();
      chk("air_peak_y", pif.ypos_player, 474);
      keys(0, 0, 0);
      frame();
      chk("air_fall1_y", pif.ypos_player, 475);
      keys(0, 0, 1);
      frame();
`ifdef PLAYER_DOUBLE_JUMP_EN
      chk("dj_press_y", pif.ypos_player, 475);
      chk("dj_press_air", pif.airborne, 1);
      frame();
      chk("dj_rise_y", pif.ypos_player, 463);
      keys(0, 0, 0);
      frame();
      chk("dj_rise2_y", pif.ypos_player, 452);
      keys(0, 0, 1);
      frame();
      chk("dj_third_press_y", pif.ypos_player, 442);
`else
      chk("air_press_y", pif.ypos_player, 477);
      frame();
      chk("air_fall3_y", pif.ypos_player, 480);
      keys(0, 0, 0);
      frame();
      chk("air_fall4_y", pif.ypos_player, 484);
      keys(0, 0, 1);
      frame();
      chk("air_press2_y", pif.ypos_player, 489);
`endif
      keys(0, 0, 0);
      n = 0;
      while (pif.airborne && n < 60) begin
         frame();
         n++;
      end
      chk("air_land_y", pif.ypos_player, 552);
      chk("air_land_air", pif.airborne, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
